// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Sequences the shared external memory bus between the
//               instruction-fetch port and the load/store data port. Each
//               transaction is a fixed three-cycle bus sequence
//               (accept / address / read-or-commit). Data traffic has
//               priority over fetch. A halt request drains the in-flight
//               transaction, then parks the bus in the halt encoding.
//               Optional build macro MEM_ARB_STARVE_EN adds a fetch
//               anti-starvation counter (STARVE_LIMIT consecutive losses).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int RDATA_W      = 12,
  parameter int WDATA_W      = 6,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_req,
  input  logic [ADDR_W-1:0]  fetch_addr,
  output logic               fetch_gnt,
  output logic               fetch_rvalid,
  output logic [RDATA_W-1:0] fetch_rdata,
  input  logic               data_req,
  input  logic               data_we,
  input  logic [ADDR_W-1:0]  data_addr,
  input  logic [WDATA_W-1:0] data_wdata,
  input  logic               data_upper,
  output logic               data_gnt,
  output logic               data_rvalid,
  output logic [RDATA_W-1:0] data_rdata,
  input  logic               halt_req,
  output logic               halted,
  output logic [ADDR_W-1:0]  bus_addr_data,
  output logic               bus_read_write,
  output logic               bus_write_commit,
  input  logic [RDATA_W-1:0] bus_rdata
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    RDATA   = 3'd2,
    WCOMMIT = 3'd3,
    HALTED  = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  // Captured request fields of the transaction in flight
  logic                r_owner_data;
  logic                r_we;
  logic                r_upper;
  logic [WDATA_W-1:0]  r_wdata;

  logic                r_halt_flag;

  logic                w_fetch_gnt;
  logic                w_data_gnt;
  logic                w_force_fetch;

  logic [ADDR_W-1:0]   w_bus_addr_data;
  logic                w_bus_read_write;
  logic                w_bus_write_commit;
  logic [ADDR_W-1:0]   w_commit_word;

  logic [ADDR_W-1:0]   r_bus_addr_data;
  logic                r_bus_read_write;
  logic                r_bus_write_commit;
  logic                r_fetch_rvalid;
  logic                r_data_rvalid;
  logic [RDATA_W-1:0]  r_fetch_rdata;
  logic [RDATA_W-1:0]  r_data_rdata;
  logic                r_halted;

  // Commit word: store data in the low bits, STOREU flag just above, rest zero
  assign w_commit_word = ADDR_W'({r_upper, r_wdata});

`ifdef MEM_ARB_STARVE_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] r_starve_cnt;

  assign w_force_fetch = fetch_req && (r_starve_cnt == CNT_W'(STARVE_LIMIT));

  // Count arbitrations that fetch lost to data; cleared whenever fetch wins
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (w_fetch_gnt) begin
      r_starve_cnt <= '0;
    end else if (w_data_gnt && fetch_req) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end
`else
  // Strict data priority: fetch is never forced ahead of data
  assign w_force_fetch = (STARVE_LIMIT < 0);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state, grants and next-cycle bus values
  always_comb begin
    w_state_next       = r_state;
    w_fetch_gnt        = 1'b0;
    w_data_gnt         = 1'b0;
    w_bus_addr_data    = '0;
    w_bus_read_write   = 1'b1;
    w_bus_write_commit = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_halt_flag) begin
          w_state_next       = HALTED;
          w_bus_write_commit = 1'b1;
        end else if (data_req && !w_force_fetch) begin
          w_data_gnt       = 1'b1;
          w_state_next     = ADDR;
          w_bus_addr_data  = data_addr;
          w_bus_read_write = ~data_we;
        end else if (fetch_req) begin
          w_fetch_gnt      = 1'b1;
          w_state_next     = ADDR;
          w_bus_addr_data  = fetch_addr;
        end
      end
      ADDR: begin
        if (r_we) begin
          w_state_next       = WCOMMIT;
          w_bus_addr_data    = w_commit_word;
          w_bus_read_write   = 1'b0;
          w_bus_write_commit = 1'b1;
        end else begin
          w_state_next = RDATA;
        end
      end
      RDATA, WCOMMIT: begin
        w_state_next = IDLE;
      end
      HALTED: begin
        w_state_next       = HALTED;
        w_bus_write_commit = 1'b1;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Capture the request fields at the accept cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner_data <= 1'b0;
      r_we         <= 1'b0;
      r_upper      <= 1'b0;
      r_wdata      <= '0;
    end else if (w_data_gnt) begin
      r_owner_data <= 1'b1;
      r_we         <= data_we;
      r_upper      <= data_upper;
      r_wdata      <= data_wdata;
    end else if (w_fetch_gnt) begin
      r_owner_data <= 1'b0;
      r_we         <= 1'b0;
    end
  end

  // Sticky halt request; only reset clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_halt_flag <= 1'b0;
    end else begin
      r_halt_flag <= r_halt_flag | halt_req;
    end
  end

  // Registered bus drive and halted indication
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bus_addr_data    <= '0;
      r_bus_read_write   <= 1'b1;
      r_bus_write_commit <= 1'b0;
      r_halted           <= 1'b0;
    end else begin
      r_bus_addr_data    <= w_bus_addr_data;
      r_bus_read_write   <= w_bus_read_write;
      r_bus_write_commit <= w_bus_write_commit;
      r_halted           <= (w_state_next == HALTED);
    end
  end

  // Read return: sample memory at the end of RDATA, strobe the owner next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_rvalid <= 1'b0;
      r_data_rvalid  <= 1'b0;
      r_fetch_rdata  <= '0;
      r_data_rdata   <= '0;
    end else begin
      r_fetch_rvalid <= (r_state == RDATA) && !r_owner_data;
      r_data_rvalid  <= (r_state == RDATA) &&  r_owner_data;
      if ((r_state == RDATA) && !r_owner_data) begin
        r_fetch_rdata <= bus_rdata;
      end
      if ((r_state == RDATA) && r_owner_data) begin
        r_data_rdata <= bus_rdata;
      end
    end
  end

  assign fetch_gnt        = w_fetch_gnt;
  assign data_gnt         = w_data_gnt;
  assign fetch_rvalid     = r_fetch_rvalid;
  assign fetch_rdata      = r_fetch_rdata;
  assign data_rvalid      = r_data_rvalid;
  assign data_rdata       = r_data_rdata;
  assign halted           = r_halted;
  assign bus_addr_data    = r_bus_addr_data;
  assign bus_read_write   = r_bus_read_write;
  assign bus_write_commit = r_bus_write_commit;

endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Sequences the single shared 10-bit external memory bus (addr_data, read_write, write_commit) between two requesters: the instruction-fetch port and the load/store data port. Runs each transaction as a fixed multi-cycle bus sequence, returns read data with a valid strobe and gives data traffic priority over fetch. It also sequences halt: drains the in-flight transaction, then parks the bus in the halt encoding.

Parameters:
ADDR_W, 10, bus/address width
RDATA_W, 12, memory read word width
WDATA_W, 6, store data width
STARVE_LIMIT, 4, consecutive fetch losses before fetch is forced to win (optional feature)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
fetch_req  in  1  fetch read request, held until granted
fetch_addr  in  ADDR_W  fetch address
fetch_gnt  out  1  fetch request accepted this cycle
fetch_rvalid  out  1  one-cycle strobe, fetch_rdata valid
fetch_rdata  out  RDATA_W  fetched word
data_req  in  1  load/store request, held until granted
data_we  in  1  1=store, 0=load
data_addr  in  ADDR_W  load/store address
data_wdata  in  WDATA_W  store data
data_upper  in  1  STOREU flag, driven onto bus bit 6 during commit
data_gnt  out  1  data request accepted this cycle
data_rvalid  out  1  one-cycle strobe, data_rdata valid
data_rdata  out  RDATA_W  loaded word
halt_req  in  1  halt request (level or pulse)
halted  out  1  bus parked in halt encoding
bus_addr_data  out  ADDR_W  shared address/data bus
bus_read_write  out  1  1=read, 0=write
bus_write_commit  out  1  write commit strobe
bus_rdata  in  RDATA_W  memory read data

Behaviour:
- States: IDLE, ADDR, RDATA, WCOMMIT, HALTED. Reset -> IDLE; all bus outputs registered.
- Reset values: bus_addr_data=0, bus_read_write=1, bus_write_commit=0, all gnt/rvalid=0, rdata regs=0, halted=0, starve count=0.
- IDLE bus: read_write=1, write_commit=0, addr_data=0.
- Arbitration (IDLE only, combinational gnt): halt latched -> no grant, go HALTED; else data_req wins over fetch_req; exactly one gnt pulses in the accept cycle N; request fields captured.
- Cycle N+1 (ADDR): addr_data=captured addr; read_write=~we; write_commit=0.
- Read: N+2 (RDATA) bus idle-read, bus_rdata sampled at end of N+2; owner's rvalid=1 with rdata in N+3; FSM back in IDLE at N+3 (next grant possible in N+3).
- Write: N+2 (WCOMMIT) addr_data[5:0]=wdata, [6]=data_upper, [9:7]=0, read_write=0, write_commit=1; IDLE in N+3; no rvalid.
- Back-to-back: requests held continuously get one grant every 3 cycles.
- halt_req sampled every cycle into sticky flag; in-flight transaction completes (including rvalid) before HALTED.
- HALTED: read_write=1, write_commit=1, addr_data=0, halted=1, no grants; exit only by rst.
- rst mid-transaction: transaction abandoned, no rvalid/commit emitted, outputs to reset values next cycle.
- Requester dropping req before gnt: no transaction.

Optional Feature:
MEM_ARB_STARVE_EN: defined -> counter increments each IDLE cycle where both req asserted and data wins, clears on fetch grant; when count==STARVE_LIMIT and fetch_req=1, fetch wins over data. Undefined -> strict data priority, no counter logic.

Test Plan:
- Reset then fetch_req, fetch_addr=0x155, bus_rdata=0xA3C in N+2 -> fetch_gnt N, addr_data=0x155 rw=1 N+1, fetch_rvalid with 0xA3C in N+3.
- Store addr=0x07F wdata=0x2A upper=1 -> N+1 addr_data=0x07F rw=0 wc=0; N+2 addr_data=0x06A rw=0 wc=1; no rvalid.
- data_req(load 0x010) and fetch_req same cycle -> data_gnt only; fetch_gnt 3 cycles later; data_rvalid then fetch_rvalid in order.
- Both held 12 cycles, strict build -> fetch never granted; with MEM_ARB_STARVE_EN, STARVE_LIMIT=4 -> fetch granted on 5th arbitration.
- halt_req during store ADDR -> commit still issued, then halted=1, rw=1, wc=1, no grants for 10 cycles.
- rst asserted in RDATA -> no rvalid, next cycle rw=1 wc=0 addr_data=0, state IDLE.
